serial_loader: RTL and testbench

UART-driven program loader and run controller for the 8-bit CPU core. It parses command frames from the UART receiver and writes program bytes into the shared 512-byte RAM through its write port. On command it starts the CPU at a given address, holds off while the CPU owns the serial link, and reports completion over the UART transmitter.

---
 rtl/serial_loader_if.sv | 38 +++
 rtl/serial_loader.sv | 173 +++++++++++++++++
 tb/tb_serial_loader.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/serial_loader_if.sv
// ============================================================================
// Module      : serial_loader_if
// Description : UART, RAM write-port and CPU-control bundle for serial_loader.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface serial_loader_if;
    logic       received;
    logic [7:0] rx_byte;
    logic [7:0] tx_byte;
    logic       transmit;
    logic       is_transmitting;
    logic [8:0] waddr;
    logic [7:0] dwrite;
    logic       write_en;
    logic [8:0] startaddr;
    logic       cpu_start;
    logic       halted;
    logic       cpu_running;
    logic       frame_err;

    // master: the loader itself
    modport master (
        input  received, rx_byte, is_transmitting, halted,
        output tx_byte, transmit, waddr, dwrite, write_en,
               startaddr, cpu_start, cpu_running, frame_err
    );

    // slave: UART, RAM and CPU around the loader
    modport slave (
        output received, rx_byte, is_transmitting, halted,
        input  tx_byte, transmit, waddr, dwrite, write_en,
               startaddr, cpu_start, cpu_running, frame_err
    );
endinterface

`default_nettype wire

// File: rtl/serial_loader.sv
// ============================================================================
// Module      : serial_loader
// Description : UART frame parser that loads program bytes into RAM, starts
//               the CPU and acknowledges completion. Optional inter-byte
//               timeout enabled by defining SERIAL_LOADER_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module serial_loader #(
    parameter int TIMEOUT_CYCLES = 12000000
) (
    input  wire logic       clk,
    input  wire logic       rst,
    serial_loader_if.master bus
);

    localparam logic [3:0] c_IDLE   = 4'd0;
    localparam logic [3:0] c_L_AH   = 4'd1;
    localparam logic [3:0] c_L_AL   = 4'd2;
    localparam logic [3:0] c_L_LEN  = 4'd3;
    localparam logic [3:0] c_L_DATA = 4'd4;
    localparam logic [3:0] c_G_AH   = 4'd5;
    localparam logic [3:0] c_G_AL   = 4'd6;
    localparam logic [3:0] c_START  = 4'd7;
    localparam logic [3:0] c_RUN    = 4'd8;
    localparam logic [3:0] c_ACK    = 4'd9;

    localparam logic [7:0] c_CMD_LOAD = 8'h4C;
    localparam logic [7:0] c_CMD_GO   = 8'h47;
    localparam logic [7:0] c_HALT_ACK = 8'h48;

    logic [3:0] r_state;
    logic [8:0] r_addr;
    logic [8:0] r_cnt;
    logic [7:0] r_csum;
    logic       r_go_ah;
    logic [7:0] r_tx_byte;
    logic       r_transmit;
    logic [8:0] r_waddr;
    logic [7:0] r_dwrite;
    logic       r_write_en;
    logic [8:0] r_startaddr;
    logic       r_cpu_start;
    logic       r_cpu_running;
    logic       r_frame_err;
    logic [7:0] w_sum;
    logic       w_timeout;

    assign w_sum = r_csum + bus.rx_byte;

`ifdef SERIAL_LOADER_TIMEOUT_EN
    logic [31:0] r_tmo;
    logic        w_timed;

    assign w_timed = (r_state >= c_L_AH) && (r_state <= c_G_AL);
    assign w_timeout = w_timed && !bus.received &&
                       (r_tmo == 32'(TIMEOUT_CYCLES - 1));

    // Held at zero outside the frame-body states, so any entry starts fresh
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_tmo <= 32'd0;
        end else if (!w_timed || bus.received) begin
            r_tmo <= 32'd0;
        end else begin
            r_tmo <= r_tmo + 32'd1;
        end
    end
`else
    assign w_timeout = 1'b0;

    // Parameter kept so both builds share one instantiation signature
    if (TIMEOUT_CYCLES > 0) begin : g_no_timeout
    end
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state       <= c_IDLE;
            r_addr        <= 9'd0;
            r_cnt         <= 9'd0;
            r_csum        <= 8'd0;
            r_go_ah       <= 1'b0;
            r_tx_byte     <= 8'd0;
            r_transmit    <= 1'b0;
            r_waddr       <= 9'd0;
            r_dwrite      <= 8'd0;
            r_write_en    <= 1'b0;
            r_startaddr   <= 9'd0;
            r_cpu_start   <= 1'b0;
            r_cpu_running <= 1'b0;
            r_frame_err   <= 1'b0;
        end else begin
            r_transmit  <= 1'b0;
            r_write_en  <= 1'b0;
            r_cpu_start <= 1'b0;
            r_frame_err <= 1'b0;
            case (r_state)
                c_IDLE: if (bus.received) begin
                    if (bus.rx_byte == c_CMD_LOAD)    r_state <= c_L_AH;
                    else if (bus.rx_byte == c_CMD_GO) r_state <= c_G_AH;
                    else                              r_frame_err <= 1'b1;
                end
                c_L_AH: if (bus.received) begin
                    r_addr[8] <= bus.rx_byte[0];
                    r_state   <= c_L_AL;
                end
                c_L_AL: if (bus.received) begin
                    r_addr[7:0] <= bus.rx_byte;
                    r_state     <= c_L_LEN;
                end
                c_L_LEN: if (bus.received) begin
                    r_cnt   <= (bus.rx_byte == 8'd0) ? 9'd256 : {1'b0, bus.rx_byte};
                    r_csum  <= 8'd0;
                    r_state <= c_L_DATA;
                end
                c_L_DATA: if (bus.received) begin
                    r_waddr    <= r_addr;
                    r_dwrite   <= bus.rx_byte;
                    r_write_en <= 1'b1;
                    r_csum     <= w_sum;
                    r_addr     <= r_addr + 9'd1;
                    r_cnt      <= r_cnt - 9'd1;
                    if (r_cnt == 9'd1) begin
                        r_tx_byte <= w_sum;
                        r_state   <= c_ACK;
                    end
                end
                c_G_AH: if (bus.received) begin
                    r_go_ah <= bus.rx_byte[0];
                    r_state <= c_G_AL;
                end
                c_G_AL: if (bus.received) begin
                    r_startaddr <= {r_go_ah, bus.rx_byte};
                    r_state     <= c_START;
                end
                c_START: begin
                    r_cpu_start   <= 1'b1;
                    r_cpu_running <= 1'b1;
                    r_state       <= c_RUN;
                end
                c_RUN: if (bus.halted) begin
                    r_cpu_running <= 1'b0;
                    r_tx_byte     <= c_HALT_ACK;
                    r_state       <= c_ACK;
                end
                c_ACK: if (!bus.is_transmitting) begin
                    r_transmit <= 1'b1;
                    r_state    <= c_IDLE;
                end
                default: r_state <= c_IDLE;
            endcase
            if (w_timeout) begin
                r_frame_err <= 1'b1;
                r_state     <= c_IDLE;
            end
        end
    end

    assign bus.tx_byte     = r_tx_byte;
    assign bus.transmit    = r_transmit;
    assign bus.waddr       = r_waddr;
    assign bus.dwrite      = r_dwrite;
    assign bus.write_en    = r_write_en;
    assign bus.startaddr   = r_startaddr;
    assign bus.cpu_start   = r_cpu_start;
    assign bus.cpu_running = r_cpu_running;
    assign bus.frame_err   = r_frame_err;

endmodule

`default_nettype wire

// File: tb/tb_serial_loader.sv
// ============================================================================
// Module      : tb_serial_loader
// Description : Self-checking bench for serial_loader against a RAM/checksum
//               reference model. Honours SERIAL_LOADER_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_serial_loader;
    logic clk = 1'b0;
    logic rst;

    serial_loader_if sif();
    serial_loader #(.TIMEOUT_CYCLES(100)) dut (.clk(clk), .rst(rst), .bus(sif));

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [7:0] dut_mem [512];
    logic [7:0] ref_mem [512];
    int wr_count = 0, tx_count = 0, start_count = 0, ferr_count = 0;
    logic [7:0] last_tx = 8'h00;
    int tx0, wr0, f0, s0;

    // Observe outputs just after each active edge
    always @(posedge clk) begin
        #1;
        if (sif.write_en) begin
            dut_mem[sif.waddr] = sif.dwrite;
            wr_count++;
        end
        if (sif.transmit) begin
            tx_count++;
            last_tx = sif.tx_byte;
        end
        if (sif.cpu_start) start_count++;
        if (sif.frame_err) ferr_count++;
    end

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle(int n);
        repeat (n) @(negedge clk);
    endtask

    // Called on a negedge; consecutive calls give back-to-back strobes
    task automatic put(logic [7:0] b);
        sif.received = 1'b1;
        sif.rx_byte  = b;
        @(negedge clk);
        sif.received = 1'b0;
    endtask

    task automatic put_w(logic [7:0] b, logic [8:0] a, string tag);
        ref_mem[a] = b;
        put(b);
        chk({tag, "_we"}, 32'(sif.write_en), 1);
        chk({tag, "_waddr"}, 32'(sif.waddr), 32'(a));
        chk({tag, "_dwrite"}, 32'(sif.dwrite), 32'(b));
    endtask

    task automatic wait_tx(int base, logic [7:0] exp, string tag);
        int n = 0;
        while (tx_count == base && n < 3000) begin
            @(negedge clk);
            n++;
        end
        idle(2);
        chk({tag, "_ack_cnt"}, 32'(tx_count - base), 1);
        chk({tag, "_ack"}, 32'(last_tx), 32'(exp));
    endtask

    task automatic chk_mem(string tag);
        int bad = 0;
        for (int i = 0; i < 512; i++)
            if (dut_mem[i] !== ref_mem[i]) bad++;
        chk({tag, "_mem"}, 32'(bad), 0);
    endtask

    // Random load frame: the model is the RAM image plus a byte-sum checksum
    task automatic do_load(int addr, int n, string tag);
        logic [7:0] d;
        logic [7:0] ah;
        logic [7:0] sum = 8'h00;
        int t0 = tx_count;
        int w0 = wr_count;
        ah = 8'($urandom);
        ah[0] = addr[8];
        put(8'h4C); put(ah); put(8'(addr)); put(8'(n));
        for (int i = 0; i < n; i++) begin
            d = 8'($urandom);
            ref_mem[(addr + i) % 512] = d;
            sum = sum + d;
            put(d);
            if ($urandom_range(0, 3) == 0) idle(1);
        end
        wait_tx(t0, sum, tag);
        chk({tag, "_wr"}, 32'(wr_count - w0), 32'(n));
        chk_mem(tag);
    endtask

    initial begin
        for (int i = 0; i < 512; i++) begin
            dut_mem[i] = 8'h00;
            ref_mem[i] = 8'h00;
        end
        sif.received = 1'b0; sif.rx_byte = 8'h00;
        sif.is_transmitting = 1'b0; sif.halted = 1'b0;
        rst = 1'b1;
        #1 rst = 1'b0;
        #1;
        chk("reset_outputs", 32'({sif.tx_byte, sif.transmit, sif.waddr, sif.dwrite, sif.write_en,
            sif.startaddr, sif.cpu_start, sif.cpu_running, sif.frame_err}), 0);
        idle(3);
        rst = 1'b1;
        idle(2);

        // Directed load, back-to-back data bytes
        tx0 = tx_count;
        put(8'h4C); put(8'h00); put(8'h10); put(8'h03);
        put_w(8'hAA, 9'h010, "load_b0");
        put_w(8'hBB, 9'h011, "load_b1");
        put_w(8'hCC, 9'h012, "load_b2");
        @(negedge clk);
        chk("load_we_single", 32'(sif.write_en), 0);
        chk("load_transmit", 32'(sif.transmit), 1);
        chk("load_tx_byte", 32'(sif.tx_byte), 32'h31);
        idle(2);
        chk("load_tx_cnt", 32'(tx_count - tx0), 1);
        chk_mem("load");

        // Address wrap 0x1FF -> 0x000
        tx0 = tx_count;
        put(8'h4C); put(8'h01); put(8'hFF); put(8'h02);
        put_w(8'h11, 9'h1FF, "wrap_b0");
        put_w(8'h22, 9'h000, "wrap_b1");
        wait_tx(tx0, 8'h33, "wrap");

        // Go frame and run phase
        tx0 = tx_count; s0 = start_count;
        put(8'h47); put(8'hFE); put(8'h10);
        chk("go_startaddr_early", 32'(sif.startaddr), 32'h010);
        chk("go_start_not_yet", 32'(sif.cpu_start), 0);
        @(negedge clk);
        chk("go_cpu_start", 32'(sif.cpu_start), 1);
        chk("go_running", 32'(sif.cpu_running), 1);
        @(negedge clk);
        chk("go_start_one_cycle", 32'(sif.cpu_start), 0);
        wr0 = wr_count;
        put(8'h4C); put(8'h00); put(8'h00); put(8'h01); put(8'hAA);
        idle(3);
        chk("run_no_writes", 32'(wr_count - wr0), 0);
        chk("run_still_running", 32'(sif.cpu_running), 1);
        sif.is_transmitting = 1'b1;
        sif.halted = 1'b1;
        @(negedge clk);
        sif.halted = 1'b0;
        chk("halt_running_clear", 32'(sif.cpu_running), 0);
        idle(5);
        chk("halt_tx_held", 32'(tx_count - tx0), 0);
        sif.is_transmitting = 1'b0;
        wait_tx(tx0, 8'h48, "halt");
        chk("go_start_cnt", 32'(start_count - s0), 1);
        chk("go_startaddr_hold", 32'(sif.startaddr), 32'h010);

        // halted outside RUN does nothing
        tx0 = tx_count;
        sif.halted = 1'b1;
        @(negedge clk);
        sif.halted = 1'b0;
        idle(4);
        chk("halt_idle_no_tx", 32'(tx_count - tx0), 0);

        // Unknown command
        f0 = ferr_count; wr0 = wr_count;
        put(8'h55);
        chk("bad_cmd_pulse", 32'(sif.frame_err), 1);
        idle(2);
        chk("bad_cmd_cnt", 32'(ferr_count - f0), 1);
        chk("bad_cmd_no_wr", 32'(wr_count - wr0), 0);
        tx0 = tx_count;
        put(8'h4C); put(8'h00); put(8'h00); put(8'h01);
        put_w(8'h7E, 9'h000, "after_bad");
        wait_tx(tx0, 8'h7E, "after_bad");
        chk_mem("after_bad");

        // Asynchronous reset in mid-frame
        put(8'h4C); put(8'h00); put(8'h20); put(8'h03);
        put_w(8'h01, 9'h020, "pre_rst_b0");
        put_w(8'h02, 9'h021, "pre_rst_b1");
        #2 rst = 1'b0;
        #1;
        chk("mid_reset_outputs", 32'({sif.tx_byte, sif.transmit, sif.waddr, sif.dwrite, sif.write_en,
            sif.startaddr, sif.cpu_start, sif.cpu_running, sif.frame_err}), 0);
        @(negedge clk);
        idle(1);
        rst = 1'b1;
        idle(1);
        tx0 = tx_count; wr0 = wr_count;
        put(8'h4C); put(8'h00); put(8'h40); put(8'h01);
        put_w(8'h09, 9'h040, "post_rst");
        wait_tx(tx0, 8'h09, "post_rst");
        chk("post_rst_wr", 32'(wr_count - wr0), 1);
        chk_mem("post_rst");

        // Randomized loads, including a full 256-byte frame crossing the wrap
        for (int k = 0; k < 6; k++)
            do_load(int'($urandom_range(0, 511)), int'($urandom_range(1, 20)), $sformatf("rand%0d", k));
        do_load(9'h150, 256, "len256");

`ifdef SERIAL_LOADER_TIMEOUT_EN
        f0 = ferr_count;
        put(8'h4C); put(8'h00);
        idle(105);
        chk("timeout_ferr", 32'(ferr_count - f0), 1);
        do_load(9'h0A0, 2, "after_timeout");
`else
        tx0 = tx_count;
        put(8'h4C); put(8'h00);
        idle(100);
        put(8'h05); put(8'h01);
        put_w(8'h5A, 9'h005, "no_timeout");
        wait_tx(tx0, 8'h5A, "no_timeout");
        chk_mem("no_timeout");
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Hard stop in case the sequence above ever stalls
    initial begin
        #2000000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule

`default_nettype wire
